// File: rtl/imem_loader_if.sv
// imem_loader_if: serial-load pins, instruction-memory write port and cpu control for imem_loader
interface imem_loader_if #(
  parameter int IMEM_SZ = 16,
  parameter int INST_W  = 8
);
  logic load_en;
  logic ser_clk;
  logic ser_data;
  logic imem_we;
  logic [$clog2(IMEM_SZ)-1:0] imem_addr;
  logic [INST_W-1:0] imem_wdata;
  logic cpu_halt;
  logic cpu_start;
  logic load_done;
  modport master (
    input  load_en, ser_clk, ser_data,
    output imem_we, imem_addr, imem_wdata, cpu_halt, cpu_start, load_done
  );
  modport slave (
    output load_en, ser_clk, ser_data,
    input  imem_we, imem_addr, imem_wdata, cpu_halt, cpu_start, load_done
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: shifts a serial instruction image into instruction memory while holding the cpu
module imem_loader #(
  parameter int IMEM_SZ = 16,
  parameter int INST_W  = 8
) (
  input logic clk,
  input logic rst,
  imem_loader_if.master bus
);
  localparam int AW = $clog2(IMEM_SZ);
  localparam int CW = $clog2(INST_W);
  typedef enum logic [1:0] {IDLE, SHIFT, WRITE, DONE} state_t;
  state_t state, state_n;
  logic [1:0] le_q, sc_q, sd_q;
  logic le_s, sc_s, sd_s, sc_prev, bit_ev, sd_ev, word_done, last_addr, abort;
  logic [INST_W-1:0] shreg;
  logic [CW-1:0] cnt;
  logic [AW-1:0] addr;
  assign le_s = le_q[1];
  assign sc_s = sc_q[1];
  assign sd_s = sd_q[1];
  assign word_done = bit_ev && cnt == CW'(INST_W - 1);
  assign last_addr = addr == AW'(IMEM_SZ - 1);
  assign abort = (state == SHIFT || state == WRITE) && !le_s;
  assign bus.cpu_halt = state == SHIFT || state == WRITE;
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // next state; dropping load_en always wins over a completing bit or a pending write
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = le_s ? SHIFT : IDLE;
      SHIFT:   state_n = !le_s ? IDLE : word_done ? WRITE : SHIFT;
      WRITE:   state_n = !le_s ? IDLE : last_addr ? DONE : SHIFT;
      DONE:    state_n = le_s ? DONE : IDLE;
      default: state_n = IDLE;
    endcase
  end
  // synchronizers, registered bit-event detect, shifter, address and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      le_q <= '0;
      sc_q <= '0;
      sd_q <= '0;
      sc_prev <= 1'b0;
      bit_ev <= 1'b0;
      sd_ev <= 1'b0;
      shreg <= '0;
      cnt <= '0;
      addr <= '0;
      bus.imem_we <= 1'b0;
      bus.imem_addr <= '0;
      bus.imem_wdata <= '0;
      bus.cpu_start <= 1'b0;
      bus.load_done <= 1'b0;
    end else begin
      le_q <= {le_q[0], bus.load_en};
      sc_q <= {sc_q[0], bus.ser_clk};
      sd_q <= {sd_q[0], bus.ser_data};
      sc_prev <= sc_s;
      bit_ev <= sc_s && !sc_prev;
      sd_ev <= sd_s;
      bus.imem_we <= state_n == WRITE;
      bus.cpu_start <= state == WRITE && state_n == DONE;
      if (state == SHIFT && bit_ev) begin
        shreg <= {shreg[INST_W-2:0], sd_ev};
        cnt <= word_done ? '0 : cnt + 1'b1;
      end
      if (state_n == WRITE) begin
        bus.imem_wdata <= {shreg[INST_W-2:0], sd_ev};
        bus.imem_addr <= addr;
      end
      if (state == IDLE && le_s) begin
        cnt <= '0;
        addr <= '0;
        bus.load_done <= 1'b0;
      end
      if (state == WRITE && le_s && !last_addr) addr <= addr + 1'b1;
      if (state == WRITE && state_n == DONE) bus.load_done <= 1'b1;
      if (abort) begin
        addr <= '0;
        bus.load_done <= 1'b0;
      end
    end
  end
endmodule
